seed_random_2_card_draw: RTL and testbench
==========================================

// Module: seed_random_2_card_draw
// PURPOSE
//  Downstream consumer of the seed_random_2 control path state output (SEND=1).
//  Each rising edge of send_i draws one card, without repetition, from a 52-card deck:
//   - a free-running 16-bit Galois LFSR picks a candidate index;
//   - a used-card mask plus linear probing guarantees a card no earlier draw has returned.
//  Drives card index/rank/suit with a one-cycle valid pulse to the blackjack game logic.
// PARAMETERS
//  SEED_RESET  16'hACE1  LFSR value at reset; also substituted when a zero seed is loaded
//  LFSR_MASK   16'hB400  Galois feedback mask (x^16+x^14+x^13+x^11+1)
// PORTS
//  clk_cp_i      in   1   clock, rising edge
//  rst_cp_i      in   1   asynchronous, active-low reset
//  send_i        in   1   control-path state (1=SEND); draw triggered on 0->1 only
//  seed_i        in   16  seed value
//  seed_load_i   in   1   load seed_i into LFSR this cycle
//  new_deck_i    in   1   clear used mask, refill deck, abort any draw in progress
//  card_valid_o  out  1   one-cycle pulse: card outputs valid
//  card_idx_o    out  6   drawn index 0..51
//  card_rank_o   out  4   1..13 (idx%13 + 1)
//  card_suit_o   out  2   0..3 (idx/13)
//  cards_left_o  out  6   undrawn cards, 52..0
//  deck_empty_o  out  1   cards_left_o==0 (combinational from count)
//  busy_o        out  1   FSM not IDLE
//  draw_err_o    out  1   one-cycle pulse: draw requested on empty deck
// BEHAVIOUR
//  Reset values:
//   - lfsr=SEED_RESET, send_q=0, used mask=0, cards_left_o=52;
//   - card_idx_o/rank/suit=0, card_valid_o=0, draw_err_o=0, busy_o=0, FSM=IDLE.
//  LFSR:
//   - every cycle: lfsr <= (lfsr>>1) ^ (lfsr[0] ? LFSR_MASK : 0);
//   - seed_load_i overrides the step: lfsr <= (seed_i==0) ? SEED_RESET : seed_i;
//   - the LFSR never holds 0.
//  Edge detect:
//   - send_q <= send_i every cycle; rise = send_i & ~send_q;
//   - send_i held high produces no repeat draw.
//  Fold: cand = lfsr[5:0] >= 52 ? lfsr[5:0]-52 : lfsr[5:0] (range 0..51).
//  FSM IDLE:
//   - rise & cards_left>0 -> cand_q <= fold(lfsr) (current, pre-step value); go PROBE;
//   - rise & cards_left==0 -> draw_err_o pulses for 1 cycle; stay IDLE.
//  FSM PROBE, one candidate per cycle:
//   - used[cand_q]=1 -> cand_q <= (cand_q==51) ? 0 : cand_q+1 (wrap);
//   - used[cand_q]=0 -> used[cand_q]<=1, cards_left--, card outputs registered,
//     card_valid_o=1 for exactly 1 cycle, go IDLE.
//  Latency:
//   - rise sampled at edge N -> valid after edge N+1 (no collision);
//   - +1 cycle per used card probed; worst case N+52.
//  Rises arriving while busy are ignored (send_q still tracks send_i).
//  new_deck_i:
//   - highest priority; at the edge: used=0, cards_left=52, FSM=IDLE;
//   - no card_valid_o and no draw_err_o that cycle; card_* outputs hold last value;
//   - a rise coincident with new_deck_i is discarded.
//  card_* outputs hold their value between draws.
//  Reset mid-PROBE: immediate return to reset values; no valid pulse.
// TESTING
//  1 Reset:
//    - all outputs at reset values; cards_left_o=52; deck_empty_o=0.
//  2 Basic draw, no collision:
//    - seed 16'h0001 loaded at edge N, send_i rise sampled at edge N+1;
//    - -> valid after N+2; idx=1, rank=2, suit=0; cards_left_o=51.
//  3 Fold, top of range:
//    - seed 16'h003F, same timing -> idx=11, rank=12, suit=0;
//    - seed 16'h0033 -> idx=51, rank=13, suit=3.
//  4 Probe wrap:
//    - after idx 51 drawn, reload 16'h0033 and draw;
//    - -> idx=0, rank=1, suit=0; valid one cycle later than test 2.
//  5 Exhaustion:
//    - 52 draws -> all 52 idx unique; deck_empty_o=1;
//    - 53rd rise -> draw_err_o 1-cycle pulse, no card_valid_o.
//  6 Abort / hold:
//    - new_deck_i during PROBE -> no valid, cards_left_o=52, busy_o=0;
//    - send_i held high 10 cycles -> exactly one draw.

Source files
------------

// File: rtl/seed_random_2_card_draw_if.sv
`default_nettype none
// ============================================================================
// Module   : seed_random_2_card_draw_if
// Purpose  : Control and card-output bundle between the seed_random_2 control
//            path / blackjack game logic (master) and the card-draw engine
//            (slave).
// Revision : 1.0 - initial release
// ============================================================================
interface seed_random_2_card_draw_if;
  logic        send_i;
  logic [15:0] seed_i;
  logic        seed_load_i;
  logic        new_deck_i;
  logic        card_valid_o;
  logic [5:0]  card_idx_o;
  logic [3:0]  card_rank_o;
  logic [1:0]  card_suit_o;
  logic [5:0]  cards_left_o;
  logic        deck_empty_o;
  logic        busy_o;
  logic        draw_err_o;

  // Draw engine side
  modport slave (
    input  send_i, seed_i, seed_load_i, new_deck_i,
    output card_valid_o, card_idx_o, card_rank_o, card_suit_o,
           cards_left_o, deck_empty_o, busy_o, draw_err_o
  );

  // Control / game-logic side
  modport master (
    output send_i, seed_i, seed_load_i, new_deck_i,
    input  card_valid_o, card_idx_o, card_rank_o, card_suit_o,
           cards_left_o, deck_empty_o, busy_o, draw_err_o
  );
endinterface
`default_nettype wire

// File: rtl/seed_random_2_card_draw.sv
`default_nettype none
// ============================================================================
// Module   : seed_random_2_card_draw
// Purpose  : Draws one card without repetition from a 52-card deck on every
//            rising edge of the SEND state. A free-running Galois LFSR picks
//            a candidate; a used-card mask with linear probing skips cards
//            already dealt.
// Revision : 1.0 - initial release
// ============================================================================
module seed_random_2_card_draw #(
  parameter logic [15:0] SEED_RESET = 16'hACE1,
  parameter logic [15:0] LFSR_MASK  = 16'hB400
) (
  input  wire                        clk_cp_i,
  input  wire                        rst_cp_i,
  seed_random_2_card_draw_if.slave   bus
);

  localparam logic [5:0] C_DECK_SIZE = 6'd52;
  localparam logic [5:0] C_LAST_IDX  = 6'd51;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PROBE = 2'd1
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic        send_q;
  logic [5:0]  cand_q, cand_d;
  logic [51:0] used_q, used_d;
  logic [5:0]  left_q, left_d;
  logic [5:0]  idx_q, idx_d;
  logic [3:0]  rank_q, rank_d;
  logic [1:0]  suit_q, suit_d;
  logic        valid_q, valid_d;
  logic        err_q, err_d;

  logic        rise_w;
  logic [5:0]  fold_w;
  logic [1:0]  suit_w;
  logic [3:0]  base_lo_w;
  logic [3:0]  rank_w;

  assign rise_w = bus.send_i & ~send_q;
  assign fold_w = (lfsr_q[5:0] >= C_DECK_SIZE) ? (lfsr_q[5:0] - C_DECK_SIZE)
                                               : lfsr_q[5:0];

  // Suit and rank of the current candidate. The rank difference is always
  // 0..12, so only the low nibble of the suit base (0,13,26,39) is needed.
  always_comb begin
    suit_w    = 2'd0;
    base_lo_w = 4'd0;
    if (cand_q >= 6'd39) begin
      suit_w    = 2'd3;
      base_lo_w = 4'd7;
    end else if (cand_q >= 6'd26) begin
      suit_w    = 2'd2;
      base_lo_w = 4'd10;
    end else if (cand_q >= 6'd13) begin
      suit_w    = 2'd1;
      base_lo_w = 4'd13;
    end
    rank_w = cand_q[3:0] - base_lo_w + 4'd1;
  end

  // LFSR next value: seed load overrides the step; a zero seed would lock up
  always_comb begin
    lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_MASK : 16'h0000);
    if (bus.seed_load_i) begin
      lfsr_d = (bus.seed_i == 16'h0000) ? SEED_RESET : bus.seed_i;
    end
  end

  // Draw FSM next-state and output logic; new deck wins over everything
  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    used_d  = used_q;
    left_d  = left_q;
    idx_d   = idx_q;
    rank_d  = rank_q;
    suit_d  = suit_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    if (bus.new_deck_i) begin
      used_d  = '0;
      left_d  = C_DECK_SIZE;
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (rise_w) begin
            if (left_q != 6'd0) begin
              cand_d  = fold_w;
              state_d = PROBE;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        PROBE: begin
          if (used_q[cand_q]) begin
            cand_d = (cand_q == C_LAST_IDX) ? 6'd0 : cand_q + 6'd1;
          end else begin
            used_d[cand_q] = 1'b1;
            left_d         = left_q - 6'd1;
            idx_d          = cand_q;
            rank_d         = rank_w;
            suit_d         = suit_w;
            valid_d        = 1'b1;
            state_d        = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and datapath registers with asynchronous active-low reset
  always_ff @(posedge clk_cp_i or negedge rst_cp_i) begin
    if (!rst_cp_i) begin
      state_q <= IDLE;
      lfsr_q  <= SEED_RESET;
      send_q  <= 1'b0;
      cand_q  <= 6'd0;
      used_q  <= '0;
      left_q  <= C_DECK_SIZE;
      idx_q   <= 6'd0;
      rank_q  <= 4'd0;
      suit_q  <= 2'd0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      send_q  <= bus.send_i;
      cand_q  <= cand_d;
      used_q  <= used_d;
      left_q  <= left_d;
      idx_q   <= idx_d;
      rank_q  <= rank_d;
      suit_q  <= suit_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign bus.card_valid_o = valid_q;
  assign bus.card_idx_o   = idx_q;
  assign bus.card_rank_o  = rank_q;
  assign bus.card_suit_o  = suit_q;
  assign bus.cards_left_o = left_q;
  assign bus.deck_empty_o = (left_q == 6'd0);
  assign bus.busy_o       = (state_q != IDLE);
  assign bus.draw_err_o   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_seed_random_2_card_draw.sv
`default_nettype none
// ============================================================================
// Module   : tb_seed_random_2_card_draw
// Purpose  : Scoreboard bench for the card-draw engine. Stimulus pushes the
//            expected card into a queue; a monitor pops and compares each
//            time card_valid_o is seen.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seed_random_2_card_draw;

  typedef struct packed {
    logic       chk_idx;   // 0: index is random, check consistency/uniqueness
    logic [5:0] idx;
    logic [3:0] rank;
    logic [1:0] suit;
    logic [5:0] left;
  } exp_t;

  logic clk;
  logic rst_n;
  seed_random_2_card_draw_if bus ();

  seed_random_2_card_draw dut (
    .clk_cp_i (clk),
    .rst_cp_i (rst_n),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  int          err_pending = 0;
  int          seen_cnt = 0;
  logic [51:0] seen = '0;
  exp_t        exp_q[$];
  exp_t        mon_e;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0d, wanted %0d", name, act, req);
    end
  endtask

  // Monitor: compares every presented card and error pulse
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.card_valid_o) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_valid: got idx %0d, wanted no card", bus.card_idx_o);
        end else begin
          mon_e = exp_q.pop_front();
          if (mon_e.chk_idx) begin
            check("card_idx", {10'd0, bus.card_idx_o}, {10'd0, mon_e.idx});
            check("card_rank", {12'd0, bus.card_rank_o}, {12'd0, mon_e.rank});
            check("card_suit", {14'd0, bus.card_suit_o}, {14'd0, mon_e.suit});
          end else begin
            check("idx_range", {15'd0, (bus.card_idx_o < 6'd52)}, 16'd1);
            check("rank_of_idx", {12'd0, bus.card_rank_o}, 16'(bus.card_idx_o % 13 + 1));
            check("suit_of_idx", {14'd0, bus.card_suit_o}, 16'(bus.card_idx_o / 13));
            if (bus.card_idx_o < 6'd52) begin
              check("idx_unique", {15'd0, seen[bus.card_idx_o]}, 16'd0);
              if (!seen[bus.card_idx_o]) seen_cnt++;
              seen[bus.card_idx_o] = 1'b1;
            end
          end
          check("cards_left", {10'd0, bus.cards_left_o}, {10'd0, mon_e.left});
        end
      end
      if (bus.draw_err_o) begin
        n_vec++;
        if (err_pending == 0) begin
          n_err++;
          $display("FAIL unexpected_draw_err: got 1, wanted 0");
        end else begin
          err_pending--;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int budget, output int lat);
    lat = 0;
    while (lat < budget) begin
      tick();
      lat++;
      if (bus.card_valid_o) return;
    end
    n_vec++;
    n_err++;
    $display("FAIL valid_timeout: got no valid in %0d cycles, wanted a card", budget);
  endtask

  // Seed at edge N, rise sampled at edge N+1, card expected from the queue
  task automatic seeded_draw(input logic [15:0] seed, input logic [5:0] idx,
                             input logic [3:0] rank, input logic [1:0] suit,
                             input logic [5:0] left, input int exp_lat, input string name);
    int lat;
    bus.seed_i      = seed;
    bus.seed_load_i = 1'b1;
    tick();
    bus.seed_load_i = 1'b0;
    exp_q.push_back('{1'b1, idx, rank, suit, left});
    bus.send_i = 1'b1;
    wait_valid(60, lat);
    check(name, 16'(lat), 16'(exp_lat));
    bus.send_i = 1'b0;
    tick();
  endtask

  task automatic pulse_new_deck();
    bus.new_deck_i = 1'b1;
    tick();
    bus.new_deck_i = 1'b0;
  endtask

  initial begin
    int lat;
    rst_n           = 1'b0;
    bus.send_i      = 1'b0;
    bus.seed_i      = 16'h0000;
    bus.seed_load_i = 1'b0;
    bus.new_deck_i  = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    // Reset values
    check("rst_valid", {15'd0, bus.card_valid_o}, 16'd0);
    check("rst_idx",   {10'd0, bus.card_idx_o},   16'd0);
    check("rst_rank",  {12'd0, bus.card_rank_o},  16'd0);
    check("rst_suit",  {14'd0, bus.card_suit_o},  16'd0);
    check("rst_left",  {10'd0, bus.cards_left_o}, 16'd52);
    check("rst_empty", {15'd0, bus.deck_empty_o}, 16'd0);
    check("rst_busy",  {15'd0, bus.busy_o},       16'd0);
    check("rst_err",   {15'd0, bus.draw_err_o},   16'd0);
    rst_n = 1'b1;
    tick();

    // Basic, fold and probe-wrap draws
    seeded_draw(16'h0001, 6'd1,  4'd2,  2'd0, 6'd51, 2, "lat_basic");
    seeded_draw(16'h003F, 6'd11, 4'd12, 2'd0, 6'd50, 2, "lat_fold_3f");
    seeded_draw(16'h0033, 6'd51, 4'd13, 2'd3, 6'd49, 2, "lat_fold_33");
    seeded_draw(16'h0033, 6'd0,  4'd1,  2'd0, 6'd48, 3, "lat_wrap");

    // Abort during PROBE: 51 and 0 are used, so the probe lasts several cycles
    bus.seed_i      = 16'h0033;
    bus.seed_load_i = 1'b1;
    tick();
    bus.seed_load_i = 1'b0;
    bus.send_i      = 1'b1;
    tick();
    check("abort_busy_before", {15'd0, bus.busy_o}, 16'd1);
    pulse_new_deck();
    check("abort_busy",  {15'd0, bus.busy_o},       16'd0);
    check("abort_left",  {10'd0, bus.cards_left_o}, 16'd52);
    check("abort_hold_idx", {10'd0, bus.card_idx_o}, 16'd0);
    bus.send_i = 1'b0;
    repeat (10) tick();

    // Exhaustion: 52 unique random cards
    seen     = '0;
    seen_cnt = 0;
    for (int i = 0; i < 52; i++) begin
      exp_q.push_back('{1'b0, 6'd0, 4'd0, 2'd0, 6'(51 - i)});
      bus.send_i = 1'b1;
      wait_valid(60, lat);
      bus.send_i = 1'b0;
      tick();
    end
    check("exhaust_unique", 16'(seen_cnt), 16'd52);
    check("exhaust_empty", {15'd0, bus.deck_empty_o}, 16'd1);
    err_pending = 1;
    bus.send_i  = 1'b1;
    repeat (4) tick();
    bus.send_i = 1'b0;
    tick();
    check("draw_err_seen", 16'(err_pending), 16'd0);
    check("empty_busy", {15'd0, bus.busy_o}, 16'd0);

    // send_i held high: exactly one draw
    pulse_new_deck();
    exp_q.push_back('{1'b0, 6'd0, 4'd0, 2'd0, 6'd51});
    seen     = '0;
    bus.send_i = 1'b1;
    repeat (10) tick();
    bus.send_i = 1'b0;
    tick();
    check("hold_left", {10'd0, bus.cards_left_o}, 16'd51);
    check("hold_queue", 16'(exp_q.size()), 16'd0);

    // Rise coincident with new_deck is discarded
    bus.new_deck_i = 1'b1;
    bus.send_i     = 1'b1;
    tick();
    bus.new_deck_i = 1'b0;
    repeat (5) tick();
    bus.send_i = 1'b0;
    tick();
    check("coinc_left", {10'd0, bus.cards_left_o}, 16'd52);
    check("coinc_busy", {15'd0, bus.busy_o},       16'd0);

    check("final_queue", 16'(exp_q.size()), 16'd0);
    check("final_err_pending", 16'(err_pending), 16'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
